// File: rtl/fixed_q88_pkg.sv
// Shared Q8.8 fixed-point definitions for the gradient step scaler and the update stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fixed_q88_pkg;

  // Number of fractional bits in a Q8.8 value.
  localparam int FRACT_BITS = 8;

  // Width of a Q16.16 product after dropping the fractional bits that Q8.8 cannot hold.
  localparam int SHIFT_W = 32 - FRACT_BITS;

  // Saturation limits, as raw bit patterns.
  localparam logic [15:0] Q8_8_MAX = 16'h7FFF;
  localparam logic [15:0] Q8_8_MIN = 16'h8000;

  typedef logic signed [15:0] q88_t;
  typedef logic signed [31:0] q1616_t;

  // Full-precision Q8.8 x Q8.8 -> Q16.16 product. A 16x16 signed product
  // always fits in 32 bits, including min*min (+2^30).
  function automatic q1616_t q88_mul(input q88_t a, input q88_t b);
    q88_mul = q1616_t'(a) * q1616_t'(b);
  endfunction

endpackage

// File: rtl/fixed_16_capped_mul.sv
// Narrows a Q16.16 product to Q8.8 (floor toward -inf) and saturates it, flagging which rail was hit.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of i_prod.
//
// Ports:
//   i_prod        Q16.16 signed product
//   o_step        Q8.8 saturated result
//   o_overflow    result was capped at Q8_8_MAX
//   o_underflow_q result was capped at Q8_8_MIN
module fixed_16_capped_mul
  import fixed_q88_pkg::*;
(
  input  logic signed [31:0] i_prod,
  output logic [15:0]        o_step,
  output logic               o_overflow,
  output logic               o_underflow_q
);

  // Q8.8 rails sign-extended to the width of the shifted product.
  localparam logic signed [SHIFT_W-1:0] W_HI = SHIFT_W'($signed(Q8_8_MAX));
  localparam logic signed [SHIFT_W-1:0] W_LO = SHIFT_W'($signed(Q8_8_MIN));

  logic signed [SHIFT_W-1:0] w_shifted;

  // Arithmetic shift floors toward -inf. The top FRACT_BITS of the 32-bit
  // shift result are pure sign copies, so keeping SHIFT_W bits loses nothing.
  assign w_shifted = SHIFT_W'(i_prod >>> FRACT_BITS);

  // The two compares are mutually exclusive, so at most one flag is ever set.
  assign o_overflow    = (w_shifted > W_HI);
  assign o_underflow_q = (w_shifted < W_LO);

  always_comb begin
    o_step = w_shifted[15:0];
    if (o_overflow) begin
      o_step = Q8_8_MAX;
    end else if (o_underflow_q) begin
      o_step = Q8_8_MIN;
    end
  end

endmodule

// File: rtl/fixed_16_step_scaler.sv
// Scales each gradient element by a per-vector Q8.8 learning rate and saturates the result to Q8.8.
// Latency: 2 cycles from input accept to step_out at 1 element/cycle.
// Backpressure: valid/ready; out_ready low freezes stage 2, then stage 1, then drops in_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           gradient element handshake
//   grad_in                     Q8.8 gradient element
//   lr_in                       Q8.8 learning rate, sampled on element 0 only
//   out_valid/out_ready         step element handshake
//   step_out                    Q8.8 saturated lr*grad
//   out_idx, out_last           dimension index of step_out, high on index DIM-1
//   overflow, underflow_q       step_out was capped high / low
//   vec_sat                     any cap in the current vector so far; meaningful with out_last
module fixed_16_step_scaler
  import fixed_q88_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      grad_in,
  input  logic [15:0]      lr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      step_out,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             overflow,
  output logic             underflow_q,
  output logic             vec_sat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  // Handshake
  logic w_s2_en;
  logic w_s1_en;
  logic w_in_fire;
  logic w_s2_load;
  logic w_out_fire;

  // Input side
  logic [IDX_W-1:0] r_in_idx;
  logic [15:0]      r_lr_q;
  logic [15:0]      w_lr_sel;
  logic [31:0]      w_prod;

  // Stage 1: raw Q16.16 product
  logic             r_s1_valid;
  logic [31:0]      r_s1_prod;
  logic [IDX_W-1:0] r_s1_idx;

  // Stage 2: saturated step
  logic             r_s2_valid;
  logic [15:0]      r_step;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_ovf;
  logic             r_udf;
  logic             r_vec_sticky;

  // Saturation unit outputs
  logic [15:0]      w_step;
  logic             w_ovf;
  logic             w_udf;

  // A stage may advance when the stage after it is empty or advancing.
  assign w_s2_en    = !r_s2_valid || out_ready;
  assign w_s1_en    = !r_s1_valid || w_s2_en;
  assign in_ready   = w_s1_en;

  assign w_in_fire  = in_valid && w_s1_en;
  assign w_s2_load  = r_s1_valid && w_s2_en;
  assign w_out_fire = r_s2_valid && out_ready;

  // Element 0 takes the live learning rate so the whole vector, including
  // its first beat, is scaled by the same value.
  assign w_lr_sel = (r_in_idx == '0) ? lr_in : r_lr_q;
  assign w_prod   = q88_mul(grad_in, w_lr_sel);

  // ---------------------------------------------------------------------
  // Index counter and learning-rate capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_idx <= '0;
      r_lr_q   <= '0;
    end else if (w_in_fire) begin
      if (r_in_idx == '0) begin
        r_lr_q <= lr_in;
      end
      r_in_idx <= (r_in_idx == LAST_IDX) ? '0 : r_in_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: register the product and its index
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_idx   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_prod <= w_prod;
        r_s1_idx  <= r_in_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: shift, saturate and register the step
  // ---------------------------------------------------------------------
  fixed_16_capped_mul u_capped_mul (
    .i_prod        (r_s1_prod),
    .o_step        (w_step),
    .o_overflow    (w_ovf),
    .o_underflow_q (w_udf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_step     <= '0;
      r_out_idx  <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_step    <= w_step;
        r_out_idx <= r_s1_idx;
        r_ovf     <= w_ovf;
        r_udf     <= w_udf;
      end
    end
  end

  // Sticky vector-saturation flag. It already includes the beat sitting in
  // stage 2. When the last beat of a vector leaves in the same cycle that the
  // next vector's first beat loads, the old history is dropped but the new
  // beat's flag is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_sticky <= 1'b0;
    end else if (w_out_fire && out_last) begin
      r_vec_sticky <= w_s2_load && (w_ovf || w_udf);
    end else if (w_s2_load) begin
      r_vec_sticky <= r_vec_sticky || w_ovf || w_udf;
    end
  end

  assign out_valid   = r_s2_valid;
  assign step_out    = r_step;
  assign out_idx     = r_out_idx;
  assign out_last    = (r_out_idx == LAST_IDX);
  assign overflow    = r_ovf;
  assign underflow_q = r_udf;
  assign vec_sat     = r_vec_sticky || r_ovf || r_udf;

endmodule

// File: tb/tb_fixed_16_step_scaler.sv
`timescale 1ns/1ps
module tb_fixed_16_step_scaler;

  localparam int DIM   = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      grad_in;
  logic [15:0]      lr_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      step_out;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             overflow;
  logic             underflow_q;
  logic             vec_sat;

  fixed_16_step_scaler #(.DIM(DIM), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .grad_in     (grad_in),
    .lr_in       (lr_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .step_out    (step_out),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .overflow    (overflow),
    .underflow_q (underflow_q),
    .vec_sat     (vec_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] step;
    int          idx;
    logic        last;
    logic        ov;
    logic        un;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: position in vector, learning rate of the vector,
  // saturation seen so far in the vector.
  int          m_idx = 0;
  logic [15:0] m_lr  = 16'h0000;
  logic        m_acc = 1'b0;

  logic ready_rand  = 1'b0;
  logic force_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Real-valued definition: step = floor(lr*grad / 256) clipped to [-32768, 32767].
  task automatic model_step(input logic [15:0] g, input logic [15:0] l,
                            output logic [15:0] s, output logic ov, output logic un);
    longint p;
    longint q;
    p = longint'($signed(g)) * longint'($signed(l));
    q = p / 256;
    if ((p % 256 != 0) && (p < 0)) q = q - 1;
    ov = 1'b0;
    un = 1'b0;
    if (q > 32767) begin
      s  = 16'h7FFF;
      ov = 1'b1;
    end else if (q < -32768) begin
      s  = 16'h8000;
      un = 1'b1;
    end else begin
      s = q[15:0];
    end
  endtask

  // Offer one element; when it will be accepted at the next rising edge,
  // push its expected response and return right after that edge.
  task automatic send(input logic [15:0] g, input logic [15:0] l);
    int   waitc;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    grad_in  = g;
    lr_in    = l;
    #1;
    while (!in_ready) begin
      waitc++;
      if (waitc > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck 0, expected 1 within 200 cycles");
        return;
      end
      @(negedge clk);
      #1;
    end
    if (m_idx == 0) m_lr = l;
    model_step(g, m_lr, e.step, e.ov, e.un);
    e.idx  = m_idx;
    e.last = (m_idx == DIM - 1);
    m_acc  = m_acc | e.ov | e.un;
    e.vs   = m_acc;
    if (e.last) m_acc = 1'b0;
    m_idx = (m_idx + 1) % DIM;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      grad_in  = 16'($urandom);
      lr_in    = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Assert reset now (caller is just past a falling edge), check reset state, release at the next falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_step_out", step_out, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow_q, 0);
    chk("rst_vec_sat", vec_sat, 0);
    exp_q.delete();
    m_idx = 0;
    m_acc = 1'b0;
    m_lr  = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
      else            out_ready = !force_stall;
    end
  end

  // Monitor: checks hold-stability under stall and scores every accepted output.
  initial begin : monitor
    logic        held;
    logic [15:0] h_step;
    logic [1:0]  h_idx;
    logic [2:0]  h_flags;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_step", step_out, h_step);
          chk("hold_idx", out_idx, h_idx);
          chk("hold_flags", {overflow, underflow_q, out_last}, h_flags);
        end
        held    = out_valid && !out_ready;
        h_step  = step_out;
        h_idx   = out_idx;
        h_flags = {overflow, underflow_q, out_last};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: step %h idx %0d, expected no output", step_out, out_idx);
          end else begin
            e = exp_q.pop_front();
            chk("step_out", step_out, e.step);
            chk("out_idx", out_idx, e.idx);
            chk("out_last", out_last, e.last);
            chk("overflow", overflow, e.ov);
            chk("underflow_q", underflow_q, e.un);
            if (e.last) chk("vec_sat", vec_sat, e.vs);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] g;
    logic [15:0] l;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    grad_in  = 16'h0000;
    lr_in    = 16'h0000;
    @(negedge clk);
    do_reset();

    // Basic: 0x0800 * 0x0020 -> 0x0100, two edges after accept.
    send(16'h0800, 16'h0020);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("basic_not_yet", out_valid, 0);
    @(negedge clk);
    #1;
    chk("basic_valid", out_valid, 1);
    chk("basic_step", step_out, 16'h0100);
    chk("basic_idx", out_idx, 0);
    chk("basic_flags", {overflow, underflow_q}, 0);
    for (int k = 1; k < DIM; k++) send(16'($urandom), 16'($urandom));

    // Saturation; lr_in changes mid-vector must be ignored.
    send(16'h7FFF, 16'h0200);
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h8000);
    send(16'h0001, 16'h8000);

    // Truncation toward -inf, then min*min.
    send(16'hFFFF, 16'h0080);
    for (int k = 1; k < DIM; k++) send(16'h0100, 16'h1234);
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h0000);
    send(16'h0100, 16'h0000);
    send(16'hFF00, 16'h0000);

    // Back-to-back identity vectors.
    for (int k = 1; k <= 8; k++) send(16'(k * 256), 16'h0100);
    drain();

    // Backpressure.
    @(posedge clk);
    force_stall = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_empty_ready", in_ready, 1);
    send(16'($urandom), 16'h0100);
    send(16'($urandom), 16'($urandom));
    @(negedge clk);
    #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    fork
      begin
        repeat (2) @(posedge clk);
        force_stall = 1'b0;
      end
    join_none
    for (int k = 2; k < 8; k++) send(16'($urandom), 16'($urandom));
    drain();

    // Reset mid-vector.
    send(16'h0400, 16'h0100);
    send(16'h0500, 16'h0100);
    @(negedge clk);
    #1;
    chk("rstmid_valid_before", out_valid, 1);
    do_reset();
    send(16'h0100, 16'h0300);
    for (int k = 1; k < DIM; k++) send(16'h0200, 16'h7777);
    drain();

    // Randomized vectors with random backpressure and input gaps.
    ready_rand = 1'b1;
    for (int v = 0; v < 60; v++) begin
      case ($urandom_range(0, 3))
        0:       l = 16'($urandom);
        1:       l = 16'h8000;
        default: l = 16'($urandom_range(0, 16'h03FF)) ^ ($urandom_range(0, 1) != 0 ? 16'hFFFF : 16'h0000);
      endcase
      for (int k = 0; k < DIM; k++) begin
        case ($urandom_range(0, 5))
          0:       g = 16'h8000;
          1:       g = 16'h7FFF;
          2:       g = 16'hFFFF;
          default: g = 16'($urandom);
        endcase
        send(g, (k == 0) ? l : 16'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
